// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared operation and FSM state encodings for the calculator core
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    COMPUTE = 2'd2,
    RESULT  = 2'd3
  } state_t;

endpackage

// File: rtl/calc_divider.sv
// rtl/calc_divider.sv - restoring shift-subtract divider, one quotient bit per cycle
// The start cycle already performs the first iteration, so done follows WIDTH-1 cycles later.
module calc_divider #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d, done_q, done_d;
  logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [WIDTH:0]   trial;
  logic             fits;

  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_dvs  = start ? divisor : dvs_q;
    trial    = {src_rem, src_quo[WIDTH-1]};
    fits     = (trial >= {1'b0, src_dvs});
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (abort) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (start || active_q) begin
      rem_d    = fits ? WIDTH'(trial - {1'b0, src_dvs}) : trial[WIDTH-1:0];
      quo_d    = {src_quo[WIDTH-2:0], fits};
      dvs_d    = src_dvs;
      cnt_d    = start ? CW'(1) : cnt_q + 1'b1;
      active_d = 1'b1;
      if (!start && cnt_q == CW'(WIDTH - 1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - two-operand calculator control FSM with registered display bus
// Optional CALC_CHAIN_EN: enter in RESULT (no error) chains the result into operand A.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH     = 14,
  parameter int MAX_VALUE = 9999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_ent,
  input  logic             btn_clr,
  input  logic [WIDTH-1:0] operand_in,
  input  logic [1:0]       op_sel,
  output logic [WIDTH-1:0] display_value,
  output logic [1:0]       state_code,
  output logic             busy,
  output logic             result_neg,
  output logic             error
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, disp_q, disp_d;
  logic             neg_q, neg_d, err_q, err_d, started_q, started_d;
  logic [WIDTH-1:0] opnd_clamped, quotient;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic             div_start, div_abort, div_done;

  calc_divider #(.WIDTH(WIDTH)) u_divider (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (a_q),
    .divisor  (b_q),
    .quotient (quotient),
    .done     (div_done)
  );

  always_comb begin
    opnd_clamped = (operand_in > MAXV) ? MAXV : operand_in;
    sum          = {1'b0, a_q} + {1'b0, b_q};
    prod         = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    neg_d        = neg_q;
    err_d        = err_q;
    started_d    = started_q;
    div_start    = 1'b0;
    div_abort    = btn_clr;

    case (state_q)
      ENTER_A: if (btn_ent) begin
        a_d     = opnd_clamped;
        state_d = ENTER_B;
      end
      ENTER_B: if (btn_ent) begin
        b_d       = opnd_clamped;
        op_d      = op_t'(op_sel);
        started_d = 1'b0;
        state_d   = COMPUTE;
      end
      COMPUTE: begin
        case (op_q)
          OP_ADD: begin
            state_d  = RESULT;
            neg_d    = 1'b0;
            err_d    = (sum > {1'b0, MAXV});
            result_d = err_d ? '0 : sum[WIDTH-1:0];
          end
          OP_SUB: begin
            state_d  = RESULT;
            neg_d    = (a_q < b_q);
            err_d    = 1'b0;
            result_d = neg_d ? b_q - a_q : a_q - b_q;
          end
          OP_MUL: begin
            state_d  = RESULT;
            neg_d    = 1'b0;
            err_d    = (prod > {{WIDTH{1'b0}}, MAXV});
            result_d = err_d ? '0 : prod[WIDTH-1:0];
          end
          default: begin
            // Divide by zero never touches the divider and resolves like a one-cycle op
            if (b_q == '0) begin
              state_d  = RESULT;
              neg_d    = 1'b0;
              err_d    = 1'b1;
              result_d = '0;
            end else if (!started_q) begin
              div_start = 1'b1;
              started_d = 1'b1;
            end else if (div_done) begin
              state_d  = RESULT;
              neg_d    = 1'b0;
              err_d    = 1'b0;
              result_d = quotient;
            end
          end
        endcase
      end
      default: if (btn_ent) begin
        neg_d = 1'b0;
        err_d = 1'b0;
        b_d   = '0;
`ifdef CALC_CHAIN_EN
        if (!err_q) begin
          a_d     = result_q;
          state_d = ENTER_B;
        end else begin
          a_d     = '0;
          state_d = ENTER_A;
        end
`else
        a_d     = '0;
        state_d = ENTER_A;
`endif
      end
    endcase

    if (btn_clr) begin
      state_d   = ENTER_A;
      a_d       = '0;
      b_d       = '0;
      result_d  = '0;
      neg_d     = 1'b0;
      err_d     = 1'b0;
      started_d = 1'b0;
      div_start = 1'b0;
    end

    case (state_d)
      ENTER_A, ENTER_B: disp_d = operand_in;
      RESULT:           disp_d = result_d;
      default:          disp_d = disp_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ENTER_A;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      disp_q    <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      disp_q    <= disp_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
      started_q <= started_d;
    end
  end

  assign display_value = disp_q;
  assign state_code    = state_q;
  assign busy          = (state_q == COMPUTE);
  assign result_neg    = neg_q;
  assign error         = err_q;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Parametrised calculator control core: captures two operands from the slider/number subsystem on successive debounced enter pulses, then computes add, subtract, multiply or divide. The result is presented on a registered display bus with negative and error flags. The block sits between the input/debounce stage and the 7-segment display driver, replacing the fixed two-operation arithmetic path. Division is iterative (one quotient bit per cycle), so the block exposes a busy indication.

## Interface
Parameters:
- WIDTH, 14, operand/result width in bits
- MAX_VALUE, 9999, largest displayable magnitude; must be < 2**WIDTH

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- btn_ent  input  1  debounced single-cycle enter pulse
- btn_clr  input  1  debounced single-cycle clear pulse
- operand_in  input  WIDTH  live operand value from the slider subsystem
- op_sel  input  2  operation: 0 add, 1 sub, 2 mul, 3 div
- display_value  output  WIDTH  registered value for the display driver
- state_code  output  2  current FSM state encoding (for status LEDs)
- busy  output  1  high while in COMPUTE
- result_neg  output  1  result of last subtract was negative
- error  output  1  overflow or divide-by-zero on last operation

## Operation
- FSM states:
  - ENTER_A=0, ENTER_B=1, COMPUTE=2, RESULT=3.
- ENTER_A:
  - display_value follows operand_in.
  - btn_ent latches operand_in into A and moves to ENTER_B.
- ENTER_B:
  - display_value follows operand_in.
  - btn_ent latches operand_in into B and op_sel into an op register, then moves to COMPUTE.
- Operand clamping:
  - Operands are clamped to MAX_VALUE when latched.
- COMPUTE:
  - add/sub/mul finish in one cycle.
  - div starts calc_divider and waits for its done signal.
  - The state then moves to RESULT, and the result, result_neg and error registers are written.
- RESULT:
  - display_value shows the result.
  - btn_ent moves to ENTER_A with A, B, result_neg and error cleared. See Configuration for the chaining variant.
- Arithmetic rules:
  - add: computed WIDTH+1 bits wide; sum > MAX_VALUE sets error and gives result 0.
  - sub: result is |A-B|; result_neg=1 when A<B. No error is possible.
  - mul: computed 2*WIDTH bits wide; product > MAX_VALUE sets error and gives result 0.
  - div: quotient floor(A/B); remainder is discarded. B=0 sets error and gives result 0 without starting the divider.
- Pulse handling:
  - btn_ent during COMPUTE is ignored, not queued.
  - op_sel is sampled only at the ENTER_B→COMPUTE transition.
- Clear:
  - btn_clr in any state goes to ENTER_A on the next edge.
  - It clears A, B, the result, result_neg and error, and aborts the divider.
  - When btn_clr and btn_ent occur in the same cycle, clear wins.

## Timing
- Reset:
  - state ENTER_A, display_value 0, state_code 0, busy 0, result_neg 0, error 0, all internal registers 0.
- Display latency:
  - display_value is registered and lags operand_in by one cycle in the ENTER states.
- add/sub/mul:
  - btn_ent sampled in ENTER_B at edge t → COMPUTE from t+1 → RESULT from t+2.
  - busy is high for exactly one cycle.
  - display_value shows the result from t+2.
- div:
  - COMPUTE from t+1; the divider runs WIDTH cycles; RESULT from t+2+WIDTH.
  - busy is high for WIDTH+1 cycles.
- div with B=0:
  - Behaves like add/sub/mul timing: RESULT at t+2.
- Flags:
  - result_neg and error change only on entry to RESULT, on clear, or on the RESULT→ENTER transition.

## Configuration
- CALC_CHAIN_EN defined:
  - btn_ent in RESULT with error=0 loads the result into A and moves to ENTER_B, so the next operation chains.
  - A negative subtract result chains its magnitude.
  - With error=1, behaviour is the same as without the macro.
- Undefined: btn_ent in RESULT always goes to ENTER_A with A cleared.

## Structure
- Shared package calc_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
  - state_t enum (ENTER_A, ENTER_B, COMPUTE, RESULT) with the encodings above.
- Sub-module calc_divider:
  - Restoring shift-subtract divider, parametrised by WIDTH.
  - Ports: clk, reset_n, start, abort, dividend, divisor, quotient, done.
  - done is a one-cycle pulse after WIDTH iterations.

## Test plan
All scenarios use WIDTH=14, MAX_VALUE=9999.
- Reset: assert reset_n=0 mid-operation → next sample shows state_code 0, display_value 0, busy 0, error 0, result_neg 0.
- Add: A=1234, B=4321, op 0 → display_value 5555 two cycles after the second ent; busy high exactly one cycle.
- Subtract: A=100, B=250, op 1 → display_value 150, result_neg 1, error 0.
- Multiply overflow: A=200, B=50, op 2 → error 1, display_value 0. Then A=99, B=101 → 9999 with error 0.
- Divide: A=9999, B=7, op 3 → busy high for 15 cycles, display_value 1428 at t+16. B=0 → error 1 at t+2.
- Clear and chain:
  - btn_clr 5 cycles into a divide → ENTER_A next cycle, busy 0, and a later divide is correct.
  - With CALC_CHAIN_EN: 5+3 then ent, B=2, op 2 → 16.
